// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO feeding the CORDIC sin/cos generator.
// Keeps an active and a shadow frequency control word (FCW), applies a
// modular phase offset, and produces arg/arg_valid plus an iq_valid flag
// lined up with the CORDIC outputs.
module nco_phase_gen #(
  parameter int ACC_WIDTH  = 32,
  parameter int ARG_WIDTH  = 16,
  parameter int CORDIC_LAT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] fcw_in,
  input  logic                 fcw_valid,
  output logic                 fcw_ready,
  input  logic [ARG_WIDTH-1:0] poff_in,
  input  logic                 poff_valid,
  input  logic                 sync,
  output logic [ARG_WIDTH-1:0] arg,
  output logic                 arg_valid,
  output logic                 iq_valid
);

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  fcw_active_q, fcw_active_d;
  logic [ACC_WIDTH-1:0]  fcw_shadow_q, fcw_shadow_d;
  logic                  pend_q, pend_d;
  logic [ARG_WIDTH-1:0]  poff_q, poff_d;
  logic                  acc_valid_q, acc_valid_d;
  logic [ARG_WIDTH-1:0]  arg_q, arg_d;
  logic                  arg_valid_q, arg_valid_d;
  logic [CORDIC_LAT-1:0] iqv_q, iqv_d;

  // Shadow-word handshake and commit; a capture needs pend low and a
  // commit needs pend high, so the two never happen on the same edge.
  always_comb begin
    fcw_shadow_d = fcw_shadow_q;
    fcw_active_d = fcw_active_q;
    pend_d       = pend_q;
    if (!pend_q && fcw_valid) begin
      fcw_shadow_d = fcw_in;
      pend_d       = 1'b1;
    end else if (pend_q && (en || sync)) begin
      fcw_active_d = fcw_shadow_q;
      pend_d       = 1'b0;
    end else begin
      pend_d       = pend_q;
    end
  end

  // Accumulator: sync clears and wins over en; the step uses the word that
  // was active before this edge so a commit never tears the phase.
  always_comb begin
    acc_d = acc_q;
    if (sync) begin
      acc_d = {ACC_WIDTH{1'b0}};
    end else if (en) begin
      acc_d = acc_q + fcw_active_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Offset register plus output stage: arg is the truncated top of acc plus
  // the offset held before this edge, all modulo 2^ARG_WIDTH.
  always_comb begin
    poff_d = poff_q;
    if (poff_valid) begin
      poff_d = poff_in;
    end else begin
      poff_d = poff_q;
    end
    arg_d       = acc_q[ACC_WIDTH-1 -: ARG_WIDTH] + poff_q;
    acc_valid_d = en | sync;
    arg_valid_d = acc_valid_q;
  end

  // iq_valid delay line: arg_valid shifted by the CORDIC pipeline depth.
  always_comb begin
    iqv_d    = iqv_q;
    iqv_d[0] = arg_valid_q;
    for (int i = 1; i < CORDIC_LAT; i++) begin
      iqv_d[i] = iqv_q[i-1];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= {ACC_WIDTH{1'b0}};
      fcw_active_q <= {ACC_WIDTH{1'b0}};
      fcw_shadow_q <= {ACC_WIDTH{1'b0}};
      pend_q       <= 1'b0;
      poff_q       <= {ARG_WIDTH{1'b0}};
      acc_valid_q  <= 1'b0;
      arg_q        <= {ARG_WIDTH{1'b0}};
      arg_valid_q  <= 1'b0;
      iqv_q        <= {CORDIC_LAT{1'b0}};
    end else begin
      acc_q        <= acc_d;
      fcw_active_q <= fcw_active_d;
      fcw_shadow_q <= fcw_shadow_d;
      pend_q       <= pend_d;
      poff_q       <= poff_d;
      acc_valid_q  <= acc_valid_d;
      arg_q        <= arg_d;
      arg_valid_q  <= arg_valid_d;
      iqv_q        <= iqv_d;
    end
  end

  assign fcw_ready = ~pend_q;
  assign arg       = arg_q;
  assign arg_valid = arg_valid_q;
  assign iq_valid  = iqv_q[CORDIC_LAT-1];

endmodule
